// File: rtl/draw_pkg.sv
// Shared types and default geometry for the frame sequencer and its raster scan counter.
// Defines the pixel coordinate and colour types, the sequencer state encoding,
// and the default screen size and erase colour.
package draw_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_SCREEN_W = 320;
    localparam int unsigned DEF_SCREEN_H = 240;
    localparam color_t      DEF_BG_COLOR = 3'b000;

endpackage

// File: rtl/raster_scan_counter.sv
// 2-D raster scan counter: sx walks 0..SCREEN_W-1 innermost, then sy 0..SCREEN_H-1.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start_i      : synchronous restart to (0,0); wins over step_i
//   step_i       : advance one pixel
//   sx_o, sy_o   : current scan position
//   last_o       : high while the position is (SCREEN_W-1, SCREEN_H-1)
module raster_scan_counter
    import draw_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   start_i,
    input  logic   step_i,
    output coord_t sx_o,
    output coord_t sy_o,
    output logic   last_o
);

    localparam coord_t XMax = coord_t'(SCREEN_W - 1);
    localparam coord_t YMax = coord_t'(SCREEN_H - 1);

    coord_t sx_q, sx_d;
    coord_t sy_q, sy_d;
    logic   x_end, y_end;

    assign x_end = (sx_q == XMax);
    assign y_end = (sy_q == YMax);

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (start_i) begin
            sx_d = '0;
            sy_d = '0;
        end else if (step_i) begin
            if (x_end) begin
                sx_d = '0;
                sy_d = y_end ? '0 : sy_q + coord_t'(1);
            end else begin
                sx_d = sx_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sx_o   = sx_q;
    assign sy_o   = sy_q;
    assign last_o = x_end && y_end;

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer between draw_controller and the VGA adapter pixel-write port.
// Each frame_tick erases the screen with a raster fill of BG_COLOR, then opens a
// draw window in which clipped draw_controller writes are forwarded.
// Ports:
//   clk, reset_n                       : clock and asynchronous active-low reset
//   frame_tick                         : one-cycle frame period pulse
//   in_x, in_y, in_color, in_plot      : pixel write from draw_controller
//   draw_en                            : high while draw_controller may plot
//   game_update                        : one-cycle pulse on entry to the erase pass
//   vga_x, vga_y, vga_color, vga_plot  : registered pixel write to the VGA adapter
//   overrun_cnt                        : saturating count of frame_ticks lost while erasing
module frame_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned SCREEN_W = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter color_t      BG_COLOR = DEF_BG_COLOR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  coord_t     in_x,
    input  coord_t     in_y,
    input  color_t     in_color,
    input  logic       in_plot,
    output logic       draw_en,
    output logic       game_update,
    output coord_t     vga_x,
    output coord_t     vga_y,
    output color_t     vga_color,
    output logic       vga_plot,
    output logic [7:0] overrun_cnt
);

    seq_state_t state_q, state_d;
    coord_t     vga_x_q, vga_x_d;
    coord_t     vga_y_q, vga_y_d;
    color_t     vga_color_q, vga_color_d;
    logic       vga_plot_q, vga_plot_d;
    logic       draw_en_q, draw_en_d;
    logic       game_update_q, game_update_d;
    logic [7:0] overrun_q, overrun_d;

    logic   scan_start, scan_step, scan_last;
    coord_t sx, sy;
    logic   in_range;

    raster_scan_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .start_i (scan_start),
        .step_i  (scan_step),
        .sx_o    (sx),
        .sy_o    (sy),
        .last_o  (scan_last)
    );

    // Full-width compare so large coordinates are clipped rather than wrapped.
    assign in_range = ({22'd0, in_x} < SCREEN_W) && ({22'd0, in_y} < SCREEN_H);

    always_comb begin
        state_d       = state_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_color_d   = vga_color_q;
        vga_plot_d    = 1'b0;
        draw_en_d     = 1'b0;
        game_update_d = 1'b0;
        overrun_d     = overrun_q;
        scan_start    = 1'b0;
        scan_step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d       = CLEAR;
                    scan_start    = 1'b1;
                    game_update_d = 1'b1;
                end
            end
            CLEAR: begin
                scan_step   = 1'b1;
                vga_plot_d  = 1'b1;
                vga_x_d     = sx;
                vga_y_d     = sy;
                vga_color_d = BG_COLOR;
                // Ticks during the erase are dropped, including one on the final pixel.
                if (frame_tick && (overrun_q != 8'hff)) begin
                    overrun_d = overrun_q + 8'd1;
                end
                if (scan_last) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // draw_en lags DRAW entry by a cycle so it never overlaps the erase writes,
                // and falls together with the game_update rise.
                draw_en_d = !frame_tick;
                if (in_plot && in_range) begin
                    vga_plot_d  = 1'b1;
                    vga_x_d     = in_x;
                    vga_y_d     = in_y;
                    vga_color_d = in_color;
                end
                if (frame_tick) begin
                    state_d       = CLEAR;
                    scan_start    = 1'b1;
                    game_update_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_color_q   <= '0;
            vga_plot_q    <= 1'b0;
            draw_en_q     <= 1'b0;
            game_update_q <= 1'b0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_color_q   <= vga_color_d;
            vga_plot_q    <= vga_plot_d;
            draw_en_q     <= draw_en_d;
            game_update_q <= game_update_d;
            overrun_q     <= overrun_d;
        end
    end

    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign vga_plot    = vga_plot_q;
    assign draw_en     = draw_en_q;
    assign game_update = game_update_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: a small 4x3 instance checked every cycle
// against a pixel-index model plus literal expectations, and a 320x240 instance used
// for overrun saturation.
module tb_frame_sequencer;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic [2:0] in_color = '0;
    logic       in_plot = 1'b0;
    logic       draw_en, game_update, vga_plot;
    logic [9:0] vga_x, vga_y;
    logic [2:0] vga_color;
    logic [7:0] overrun_cnt;

    logic       rst2_n = 1'b0;
    logic       tick2 = 1'b0;
    logic [9:0] zx = '0;
    logic [9:0] zy = '0;
    logic [2:0] zc = '0;
    logic       zp = 1'b0;
    logic       b_den, b_gu, b_plot;
    logic [9:0] b_x, b_y;
    logic [2:0] b_c;
    logic [7:0] b_ovr;

    int n_pass = 0;
    int n_total = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    frame_sequencer #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .BG_COLOR (3'b000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_color    (in_color),
        .in_plot     (in_plot),
        .draw_en     (draw_en),
        .game_update (game_update),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_plot    (vga_plot),
        .overrun_cnt (overrun_cnt)
    );

    frame_sequencer #(
        .SCREEN_W (320),
        .SCREEN_H (240),
        .BG_COLOR (3'b000)
    ) dut_big (
        .clk         (clk),
        .reset_n     (rst2_n),
        .frame_tick  (tick2),
        .in_x        (zx),
        .in_y        (zy),
        .in_color    (zc),
        .in_plot     (zp),
        .draw_en     (b_den),
        .game_update (b_gu),
        .vga_x       (b_x),
        .vga_y       (b_y),
        .vga_color   (b_c),
        .vga_plot    (b_plot),
        .overrun_cnt (b_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle, 1 erasing (pixel index m_idx), 2 drawing.
    int         m_mode = 0;
    int         m_idx = 0;
    int         m_ovr = 0;
    logic [9:0] e_x = '0;
    logic [9:0] e_y = '0;
    logic [2:0] e_c = '0;
    logic       e_plot = 1'b0;
    logic       e_den = 1'b0;
    logic       e_gu = 1'b0;

    task automatic model_step();
        if (!reset_n) begin
            m_mode = 0; m_idx = 0; m_ovr = 0;
            e_x = '0; e_y = '0; e_c = '0; e_plot = 0; e_den = 0; e_gu = 0;
            return;
        end
        case (m_mode)
            0: begin
                e_plot = 0; e_den = 0; e_gu = frame_tick;
                if (frame_tick) begin m_mode = 1; m_idx = 0; end
            end
            1: begin
                e_plot = 1; e_den = 0; e_gu = 0;
                e_x = 10'(m_idx % W);
                e_y = 10'(m_idx / W);
                e_c = 3'b000;
                if (frame_tick && m_ovr < 255) m_ovr++;
                if (m_idx == W * H - 1) m_mode = 2;
                else m_idx++;
            end
            default: begin
                e_den = !frame_tick; e_gu = frame_tick;
                if (in_plot && int'(in_x) < W && int'(in_y) < H) begin
                    e_plot = 1; e_x = in_x; e_y = in_y; e_c = in_color;
                end else begin
                    e_plot = 0;
                end
                if (frame_tick) begin m_mode = 1; m_idx = 0; end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cmp_plot", 32'(vga_plot), 32'(e_plot));
            chk("cmp_x", 32'(vga_x), 32'(e_x));
            chk("cmp_y", 32'(vga_y), 32'(e_y));
            chk("cmp_color", 32'(vga_color), 32'(e_c));
            chk("cmp_draw_en", 32'(draw_en), 32'(e_den));
            chk("cmp_game_update", 32'(game_update), 32'(e_gu));
            chk("cmp_overrun", 32'(overrun_cnt), 32'(m_ovr));
        end
    end

    int xs [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int ys [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int cx [3]  = '{4, 0, 1023};
    int cy [3]  = '{0, 3, 0};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_draw_en", 32'(draw_en), 0);
        chk("rst_game_update", 32'(game_update), 0);
        chk("rst_overrun", 32'(overrun_cnt), 0);
        chk("rst_x", 32'(vga_x), 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // First frame: one game_update then 12 background writes in raster order.
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("f1_gu", 32'(game_update), 1);
        chk("f1_gu_plot", 32'(vga_plot), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("f1_plot", 32'(vga_plot), 1);
            chk("f1_x", 32'(vga_x), 32'(xs[i]));
            chk("f1_y", 32'(vga_y), 32'(ys[i]));
            chk("f1_color", 32'(vga_color), 0);
            chk("f1_gu_low", 32'(game_update), 0);
            chk("f1_den_low", 32'(draw_en), 0);
        end
        @(negedge clk);
        chk("f1_den_rise", 32'(draw_en), 1);
        chk("f1_plot_done", 32'(vga_plot), 0);

        // In-range draw pixel forwarded one cycle later, then held.
        in_plot = 1'b1; in_x = 10'd2; in_y = 10'd1; in_color = 3'b101;
        @(negedge clk);
        in_plot = 1'b0;
        chk("draw_plot", 32'(vga_plot), 1);
        chk("draw_x", 32'(vga_x), 2);
        chk("draw_y", 32'(vga_y), 1);
        chk("draw_color", 32'(vga_color), 5);
        @(negedge clk);
        chk("draw_plot_off", 32'(vga_plot), 0);
        chk("draw_x_hold", 32'(vga_x), 2);

        // Out-of-range pixels are dropped.
        for (int i = 0; i < 3; i++) begin
            in_plot = 1'b1; in_x = 10'(cx[i]); in_y = 10'(cy[i]);
            @(negedge clk);
            chk("clip_plot", 32'(vga_plot), 0);
        end
        in_plot = 1'b0; in_x = '0; in_y = '0;

        // Overrun: ticks at clear pixel 5 and on the final clear cycle.
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("f2_gu", 32'(game_update), 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("f2_plot", 32'(vga_plot), 1);
            chk("f2_x", 32'(vga_x), 32'(xs[i]));
            chk("f2_y", 32'(vga_y), 32'(ys[i]));
            chk("f2_gu_low", 32'(game_update), 0);
            frame_tick = (i == 5 || i == 10);
        end
        @(negedge clk);
        chk("f2_den", 32'(draw_en), 1);
        chk("f2_gu_none", 32'(game_update), 0);
        chk("f2_overrun", 32'(overrun_cnt), 2);

        // Asynchronous reset in the middle of a clear.
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("mid_x_before", 32'(vga_x), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_plot", 32'(vga_plot), 0);
        chk("async_den", 32'(draw_en), 0);
        chk("async_overrun", 32'(overrun_cnt), 0);
        chk("async_x", 32'(vga_x), 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk("f3_gu", 32'(game_update), 1);
        @(negedge clk);
        chk("f3_plot", 32'(vga_plot), 1);
        chk("f3_x", 32'(vga_x), 0);
        chk("f3_y", 32'(vga_y), 0);
        repeat (13) @(negedge clk);
        chk("f3_den", 32'(draw_en), 1);

        // Saturation on the full-size instance: 300 ticks during one clear.
        rst2_n = 1'b1;
        @(negedge clk); tick2 = 1'b1;
        @(negedge clk);
        chk("big_gu", 32'(b_gu), 1);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 100) chk("big_ovr_100", 32'(b_ovr), 100);
            if (k == 255) chk("big_ovr_255", 32'(b_ovr), 255);
        end
        tick2 = 1'b0;
        chk("big_ovr_sat", 32'(b_ovr), 255);
        chk("big_plot", 32'(b_plot), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Sits directly downstream of draw_controller and upstream of the VGA adapter's pixel-write port.
- Per frame, on each frame_tick it first erases the screen with a raster fill of BG_COLOR. It then opens a draw window in which draw_controller pixel writes are clipped and forwarded to the adapter.
- It issues a one-cycle game_update pulse at the start of each erase, so entity registers change while nothing is being drawn.

Parameters:
- SCREEN_W, 320, visible width in pixels; valid x range 0..SCREEN_W-1
- SCREEN_H, 240, visible height in pixels; valid y range 0..SCREEN_H-1
- BG_COLOR, 3'b000, fill colour used by the erase pass

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse marking the frame period (e.g. 60 Hz divider)
- in_x  in  10  pixel x from draw_controller
- in_y  in  10  pixel y from draw_controller
- in_color  in  3  pixel colour from draw_controller
- in_plot  in  1  pixel write strobe from draw_controller
- draw_en  out  1  high only in DRAW; draw_controller may treat low as "hold"
- game_update  out  1  one-cycle pulse on entry to CLEAR
- vga_x  out  10  pixel x to VGA adapter
- vga_y  out  10  pixel y to VGA adapter
- vga_color  out  3  pixel colour to VGA adapter
- vga_plot  out  1  write strobe to VGA adapter
- overrun_cnt  out  8  saturating count of frame_ticks lost during CLEAR

Behaviour:
- Reset: clk with asynchronous active-low reset_n.
  - Asserting reset_n low immediately forces state IDLE, including mid-CLEAR or mid-DRAW.
  - All outputs and counters go to 0: vga_x, vga_y, vga_color, vga_plot, draw_en, game_update, overrun_cnt, scan counters.
  - A partial clear is abandoned; no resume.
- States: IDLE, CLEAR, DRAW.
  - IDLE: outputs idle. frame_tick moves to CLEAR and pulses game_update.
  - CLEAR: the scan counter raster-walks sx 0..SCREEN_W-1 innermost, then sy 0..SCREEN_H-1, one pixel per cycle.
    - Each cycle it registers vga_x=sx, vga_y=sy, vga_color=BG_COLOR, vga_plot=1.
    - The write at (SCREEN_W-1, SCREEN_H-1) is the last; the next state is DRAW.
    - Exactly SCREEN_W*SCREEN_H plot cycles per clear.
    - in_plot is ignored during CLEAR.
  - DRAW: draw_en=1.
    - If in_plot=1, in_x<SCREEN_W and in_y<SCREEN_H, then next cycle vga_x/vga_y/vga_color copy the inputs and vga_plot=1.
    - Otherwise vga_plot=0; out-of-range pixels are silently dropped.
    - frame_tick moves to CLEAR, resets the scan counter to (0,0) and pulses game_update.
- Latency: all vga_* outputs are registered, 1 cycle from input or counter to output. No combinational input-to-output path.
- game_update:
  - Asserted in the cycle after the frame_tick that causes entry to CLEAR; exactly 1 cycle wide.
  - frame_tick arriving in the same cycle as the CLEAR→DRAW transition counts as in CLEAR: it is ignored and counted.
- Overrun:
  - frame_tick while in CLEAR is not queued; overrun_cnt increments and saturates at 255.
  - The clear completes normally.
- draw_en and vga_plot from CLEAR never overlap: draw_en drops in the cycle game_update rises.
- Counters: sx and sy are 10 bits. Comparisons use the full 10-bit value, so in_x=1023 is clipped, not wrapped.
- vga_x/vga_y/vga_color hold their last value when vga_plot=0.

Decomposition:
- Package draw_pkg:
  - coord_t: 10-bit pixel coordinate
  - color_t: 3-bit colour
  - seq_state_t enum: IDLE, CLEAR, DRAW
  - SCREEN_W/SCREEN_H defaults
  - BG_COLOR default
- Sub-module raster_scan_counter:
  - Owns the 2-D sx/sy counter.
  - Inputs: clk, reset_n, start (sync clear to 0,0), step.
  - Outputs: sx, sy, last (high when at (W-1,H-1)).
- frame_sequencer instantiates raster_scan_counter and holds the FSM, clip compare, output registers and overrun counter.

Test Plan:
- SCREEN_W=4, SCREEN_H=3; reset, then frame_tick:
  - game_update is 1 for exactly 1 cycle.
  - 12 consecutive vga_plot cycles follow, with (x,y) = (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), color 0.
  - draw_en rises the cycle after (3,2).
- In DRAW, drive in_plot=1, in_x=2, in_y=1, in_color=3'b101 for 1 cycle: next cycle vga_plot=1, vga_x=2, vga_y=1, vga_color=101; the following cycle vga_plot=0.
- In DRAW, drive in_plot=1 with in_x=4, in_y=0, then in_x=0, in_y=3, then in_x=1023: vga_plot stays 0 throughout.
- frame_tick at clear pixel 5, and again in the final clear cycle:
  - overrun_cnt=2.
  - Clear still emits all 12 writes; no second game_update.
- Reset mid-clear:
  - Drop reset_n during pixel 7: vga_plot=0 and draw_en=0 immediately (asynchronous, before next edge); state IDLE.
  - The next frame_tick restarts the clear at (0,0).
- Saturation: 300 frame_ticks during a long clear (SCREEN_W=320, SCREEN_H=240) → overrun_cnt=255.
